// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the dual-SRAM request arbiter and its helpers.
package ram_arb_pkg;

  localparam int DEF_ADDR_W  = 17;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    RESP    = 3'd3,
    RELEASE = 3'd4
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Clearable saturating cycle counter; hit is high in the cycle whose
// increment would bring the count to LIMIT.
module arb_timeout_cnt
  import ram_arb_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] TOP  = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != TOP)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt >= LAST);

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter (instruction fetch / data) in front of the dual-SRAM block.
// Build option ARB_ROUND_ROBIN_EN: alternate priority on ties instead of d-first.
//
// state   | meaning
// IDLE    | no access; sample requests and latch the winner
// ISSUE   | drive enable/strobes low-active toward storage
// WAIT    | hold bus stable until mem_done or timeout
// RESP    | pulse ack (and err) to the granted port, drop strobes
// RELEASE | wait for mem_done to fall (bounded by timeout)
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_ack,
  output logic              i_err,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  gnt_e              gnt_q;
  logic              we_q;
  logic              err_q;
  logic              cap_q;
  logic [DATA_W-1:0] rd_q;
  logic              any_req;
  logic              pick_d;
  logic              prio_d;
  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_hit;

`ifdef ARB_ROUND_ROBIN_EN
  logic prio_d_q;

  // The port served last loses the next tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_d_q <= 1'b1;
    end else if (state_q == RESP) begin
      prio_d_q <= (gnt_q == GNT_I);
    end
  end

  assign prio_d = prio_d_q;
`else
  assign prio_d = 1'b1;
`endif

  assign any_req = i_req | d_req;
  assign pick_d  = d_req & (~i_req | prio_d);

  // One counter serves both the WAIT timeout and the RELEASE bound.
  assign cnt_clr = (state_q == ISSUE) || (state_q == RESP);
  assign cnt_en  = (state_q == WAIT) || (state_q == RELEASE);

  arb_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .hit (cnt_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mem_done || cnt_hit) state_d = RESP;
      RESP:    state_d = RELEASE;
      RELEASE: if (!mem_done || cnt_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q     <= GNT_I;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      cap_q     <= 1'b0;
      rd_q      <= '0;
      mem_en    <= 1'b1;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      i_err     <= 1'b0;
      i_rdata   <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      i_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      busy  <= (state_d != IDLE);
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q     <= pick_d ? GNT_D : GNT_I;
            we_q      <= pick_d ? d_we : i_we;
            mem_addr  <= pick_d ? d_addr : i_addr;
            mem_wdata <= pick_d ? d_wdata : i_wdata;
            err_q     <= 1'b0;
            cap_q     <= 1'b0;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= we_q;
          mem_re <= ~we_q;
        end
        WAIT: begin
          // done wins over a coinciding timeout
          if (mem_done) begin
            cap_q <= ~we_q;
            rd_q  <= mem_rdata;
          end else if (cnt_hit) begin
            err_q <= 1'b1;
          end
        end
        RESP: begin
          mem_en <= 1'b1;
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          if (gnt_q == GNT_D) begin
            d_ack <= 1'b1;
            d_err <= err_q;
            if (cap_q) d_rdata <= rd_q;
          end else begin
            i_ack <= 1'b1;
            i_err <= err_q;
            if (cap_q) i_rdata <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed accesses push expected acks,
// a monitor pops and compares on every ack; storage is a small reactive model.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0, i_we = 1'b0;
  logic [16:0] i_addr = '0;
  logic [15:0] i_wdata = '0;
  logic        i_ack, i_err;
  logic [15:0] i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [16:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_ack, d_err;
  logic [15:0] d_rdata;
  logic        mem_en, mem_re, mem_we;
  logic [16:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_done = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  int cfg_dly = 1, cfg_hold = 0;
  bit cfg_stuck = 1'b0;
  int lowcnt = 0, hold_cnt = 0;

  logic [15:0] exp_rd_i = '0, exp_rd_d = '0;

  typedef struct {
    bit          pd;
    bit          err;
    logic [15:0] rd_i;
    logic [15:0] rd_d;
  } sb_t;
  sb_t sb_q[$];

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Storage model: done after cfg_dly enabled cycles, held cfg_hold cycles past release.
  always @(negedge clk) begin
    mem_rdata = mem_addr[15:0] ^ 16'h1224;
    if (!rst) begin
      mem_done = 1'b0;
      lowcnt   = 0;
    end else if (!mem_en) begin
      lowcnt++;
      if (!cfg_stuck && lowcnt >= cfg_dly && !mem_done) begin
        mem_done = 1'b1;
        hold_cnt = 0;
      end
    end else begin
      lowcnt = 0;
      if (mem_done) begin
        if (hold_cnt >= cfg_hold) mem_done = 1'b0;
        else hold_cnt++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input bit pd, input bit we, input logic [16:0] addr, input bit err);
    sb_t e;
    if (!we && !err) begin
      if (pd) exp_rd_d = addr[15:0] ^ 16'h1224;
      else    exp_rd_i = addr[15:0] ^ 16'h1224;
    end
    e.pd = pd; e.err = err; e.rd_i = exp_rd_i; e.rd_d = exp_rd_d;
    sb_q.push_back(e);
  endtask

  // Monitor: every ack pops one expected entry.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", 32'({d_ack, i_ack}), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("ack_port", 32'({d_ack, i_ack}), e.pd ? 32'd2 : 32'd1);
          chk("ack_err", 32'({d_err, i_err}), e.err ? (e.pd ? 32'd2 : 32'd1) : 32'd0);
          chk("i_rdata", 32'(i_rdata), 32'(e.rd_i));
          chk("d_rdata", 32'(d_rdata), 32'(e.rd_d));
        end
      end
    end
  end

  task automatic access(input bit pd, input bit we, input logic [16:0] addr, input logic [15:0] wd,
                        input int dly, input int hold, input bit stuck, input bit exp_err,
                        input int exp_low, input int exp_bdly, input bit pend_i);
    int          low = 0;
    int          bcyc = 0;
    int          bad_en = 0;
    bit          got = 1'b0;
    bit          seen = 1'b0;
    logic [16:0] a_s = '0;
    logic [15:0] w_s = '0;
    logic        re_s = 1'b0;
    logic        we_s = 1'b0;
    cfg_dly = dly; cfg_hold = hold; cfg_stuck = stuck;
    push_exp(pd, we, addr, exp_err);
    if (pd) begin d_we = we; d_addr = addr; d_wdata = wd; d_req = 1'b1; end
    else    begin i_we = we; i_addr = addr; i_wdata = wd; i_req = 1'b1; end
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (!mem_en) begin
        if (!seen) begin
          seen = 1'b1; a_s = mem_addr; w_s = mem_wdata; re_s = mem_re; we_s = mem_we;
        end
        low++;
      end
      if (pd ? d_ack : i_ack) begin got = 1'b1; break; end
    end
    if (pd) d_req = 1'b0; else i_req = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
    chk("en_low_cycles", 32'(low), 32'(exp_low));
    chk("mem_addr", 32'(a_s), 32'(addr));
    chk("mem_we", 32'(we_s), 32'(we));
    chk("mem_re", 32'(re_s), 32'(!we));
    if (we) chk("mem_wdata", 32'(w_s), 32'(wd));
    if (pend_i) begin i_we = 1'b0; i_addr = 17'h000A0; i_req = 1'b1; end
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      bcyc++;
      if (!mem_en) bad_en++;
      if (!busy) break;
    end
    chk("busy_drop_cycles", 32'(bcyc), 32'(exp_bdly));
    chk("en_held_in_release", 32'(bad_en), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  rem_d, rem_i;
    bit  raise_d, raise_i;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'd1);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rdata", 32'({i_rdata, d_rdata}), 32'd0);
    chk("rst_ack_err", 32'({i_ack, d_ack, i_err, d_err}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // i read, done 2 cycles in: rdata 0x1234
    access(1'b0, 1'b0, 17'h00010, 16'h0000, 2, 0, 1'b0, 1'b0, 3, 1, 1'b0);
    // d read, minimum latency
    access(1'b1, 1'b0, 17'h10030, 16'h0000, 1, 0, 1'b0, 1'b0, 2, 1, 1'b0);
    // d write to bank 2: d_rdata must stay 0x1214
    access(1'b1, 1'b1, 17'h1ABCD, 16'hBEEF, 1, 0, 1'b0, 1'b0, 2, 1, 1'b0);
    // timeout: 15 WAIT + RESP with mem_en low, err set
    access(1'b1, 1'b0, 17'h00070, 16'h0000, 1, 0, 1'b1, 1'b1, 16, 1, 1'b0);
    // done on the 15th WAIT cycle: done wins, no err
    access(1'b0, 1'b0, 17'h00080, 16'h0000, 15, 0, 1'b0, 1'b0, 16, 1, 1'b0);
    // slow done release with a pending i request
    access(1'b1, 1'b0, 17'h10090, 16'h0000, 1, 3, 1'b0, 1'b0, 2, 4, 1'b1);
    access(1'b0, 1'b0, 17'h000A0, 16'h0000, 1, 0, 1'b0, 1'b0, 2, 1, 1'b0);
    // done stuck high: RELEASE gives up after TIMEOUT cycles
    access(1'b1, 1'b0, 17'h000B0, 16'h0000, 1, 20, 1'b0, 1'b0, 2, 15, 1'b0);
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (!mem_done) break;
    end
    chk("done_fell", 32'(mem_done), 32'd0);

    // reset in the middle of WAIT
    cfg_stuck = 1'b1;
    d_we = 1'b0; d_addr = 17'h00050; d_req = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (!mem_en) break;
    end
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_async_mem_en", 32'(mem_en), 32'd1);
    chk("rst_async_mem_re", 32'(mem_re), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_rdata", 32'({i_rdata, d_rdata}), 32'd0);
    exp_rd_i = '0; exp_rd_d = '0;
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    cfg_stuck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_reset", 32'({busy, mem_en}), 32'd1);
    access(1'b0, 1'b0, 17'h00060, 16'h0000, 1, 0, 1'b0, 1'b0, 2, 1, 1'b0);

    // contention: d wants 3 accesses, i wants 2, both re-raise after ack
    cfg_dly = 1; cfg_hold = 0; cfg_stuck = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    push_exp(1'b1, 1'b0, 17'h10030, 1'b0);
    push_exp(1'b0, 1'b0, 17'h00020, 1'b0);
    push_exp(1'b1, 1'b0, 17'h10030, 1'b0);
    push_exp(1'b0, 1'b0, 17'h00020, 1'b0);
    push_exp(1'b1, 1'b0, 17'h10030, 1'b0);
`else
    push_exp(1'b1, 1'b0, 17'h10030, 1'b0);
    push_exp(1'b1, 1'b0, 17'h10030, 1'b0);
    push_exp(1'b1, 1'b0, 17'h10030, 1'b0);
    push_exp(1'b0, 1'b0, 17'h00020, 1'b0);
    push_exp(1'b0, 1'b0, 17'h00020, 1'b0);
`endif
    d_we = 1'b0; d_addr = 17'h10030;
    i_we = 1'b0; i_addr = 17'h00020;
    rem_d = 3; rem_i = 2; raise_d = 1'b0; raise_i = 1'b0;
    d_req = 1'b1; i_req = 1'b1;
    for (int c = 0; c < 200 && (rem_d > 0 || rem_i > 0); c++) begin
      @(posedge clk); #1;
      if (raise_d) begin d_req = 1'b1; raise_d = 1'b0; end
      if (raise_i) begin i_req = 1'b1; raise_i = 1'b0; end
      if (d_ack) begin d_req = 1'b0; rem_d--; raise_d = (rem_d > 0); end
      if (i_ack) begin i_req = 1'b0; rem_i--; raise_i = (rem_i > 0); end
    end
    d_req = 1'b0; i_req = 1'b0;
    chk("contention_left", 32'(rem_d + rem_i), 32'd0);
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("busy_end", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
